// File: rtl/bus_arbiter.sv
// Three-requester round-robin arbiter (CPU, DMA, debug) for a single external bus.
// Define BUS_ARBITER_TIMEOUT_EN to enable the bus-wait watchdog that aborts with o_err.
module bus_arbiter #(
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [2:0]            i_req,
    input  logic [2:0]            i_we,
    input  logic [3*ADDR_W-1:0]   i_addr,
    input  logic [3*DATA_W-1:0]   i_wdata,
    output logic [2:0]            o_gnt,
    output logic [2:0]            o_ack,
    output logic                  o_err,
    output logic [DATA_W-1:0]     o_rdata,
    output logic                  o_bus_clk,
    output logic                  o_bus_we,
    output logic [ADDR_W-1:0]     o_bus_addr,
    output logic [DATA_W-1:0]     o_bus_data,
    input  logic [DATA_W-1:0]     i_bus_data,
    input  logic                  i_bus_data_ready
);

    localparam int unsigned CNT_W = 16;

    if (TIMEOUT_CYC == 0 || TIMEOUT_CYC > 65535) begin : g_bad_timeout
        $error("bus_arbiter: TIMEOUT_CYC must be within 1..65535");
    end

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BUS     = 2'd1,
        ST_RECOVER = 2'd2
    } state_t;

    state_t              state;
    logic [1:0]          ptr;
    logic                pick_vld;
    logic [1:0]          pick;
    logic [ADDR_W-1:0]   sel_addr;
    logic [DATA_W-1:0]   sel_wdata;
    logic                sel_we;

`ifdef BUS_ARBITER_TIMEOUT_EN
    logic [CNT_W-1:0]    tmo_cnt;
`endif

    // (base + off) mod 3 for base, off in 0..2
    function automatic logic [1:0] rr_idx(input logic [1:0] base, input logic [1:0] off);
        logic [2:0] s;
        s = {1'b0, base} + {1'b0, off};
        return (s >= 3'd3) ? 2'(s - 3'd3) : s[1:0];
    endfunction

    // Round-robin winner: scan from the farthest offset down so the closest to ptr wins
    always_comb begin
        pick_vld = 1'b0;
        pick     = ptr;
        for (int off = 2; off >= 0; off--) begin
            if (i_req[rr_idx(ptr, 2'(off))]) begin
                pick_vld = 1'b1;
                pick     = rr_idx(ptr, 2'(off));
            end
        end
    end

    always_comb begin
        sel_addr  = i_addr[0 +: ADDR_W];
        sel_wdata = i_wdata[0 +: DATA_W];
        sel_we    = i_we[0];
        case (pick)
            2'd1: begin
                sel_addr  = i_addr[ADDR_W +: ADDR_W];
                sel_wdata = i_wdata[DATA_W +: DATA_W];
                sel_we    = i_we[1];
            end
            2'd2: begin
                sel_addr  = i_addr[2*ADDR_W +: ADDR_W];
                sel_wdata = i_wdata[2*DATA_W +: DATA_W];
                sel_we    = i_we[2];
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state      <= ST_IDLE;
            ptr        <= 2'd0;
            o_gnt      <= 3'b000;
            o_ack      <= 3'b000;
            o_err      <= 1'b0;
            o_rdata    <= '0;
            o_bus_clk  <= 1'b0;
            o_bus_we   <= 1'b0;
            o_bus_addr <= '0;
            o_bus_data <= '0;
`ifdef BUS_ARBITER_TIMEOUT_EN
            tmo_cnt    <= '0;
`endif
        end else begin
            o_ack <= 3'b000;
            o_err <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (pick_vld) begin
                        o_gnt      <= 3'(3'b001 << pick);
                        o_bus_addr <= sel_addr;
                        o_bus_we   <= sel_we;
                        o_bus_data <= sel_wdata;
                        o_bus_clk  <= 1'b1;
                        ptr        <= (pick == 2'd2) ? 2'd0 : 2'(pick + 2'd1);
`ifdef BUS_ARBITER_TIMEOUT_EN
                        tmo_cnt    <= '0;
`endif
                        state      <= ST_BUS;
                    end
                end
                ST_BUS: begin
                    // Ready takes priority over a coincident watchdog expiry
                    if (i_bus_data_ready) begin
                        o_bus_clk <= 1'b0;
                        if (!o_bus_we) begin
                            o_rdata <= i_bus_data;
                        end
                        o_ack     <= o_gnt;
                        o_gnt     <= 3'b000;
                        state     <= ST_RECOVER;
`ifdef BUS_ARBITER_TIMEOUT_EN
                    end else if (tmo_cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
                        o_bus_clk <= 1'b0;
                        o_ack     <= o_gnt;
                        o_err     <= 1'b1;
                        o_gnt     <= 3'b000;
                        state     <= ST_RECOVER;
                    end else begin
                        tmo_cnt   <= tmo_cnt + CNT_W'(1);
`endif
                    end
                end
                ST_RECOVER: begin
                    if (!i_bus_data_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter; completions are checked against a scoreboard of expected acks.
module tb_bus_arbiter;

    localparam int unsigned AW  = 32;
    localparam int unsigned DW  = 32;
    localparam int unsigned TMO = 4;

    logic              i_clk = 1'b0;
    logic              i_rst;
    logic [2:0]        i_req;
    logic [2:0]        i_we;
    logic [3*AW-1:0]   i_addr;
    logic [3*DW-1:0]   i_wdata;
    logic [2:0]        o_gnt;
    logic [2:0]        o_ack;
    logic              o_err;
    logic [DW-1:0]     o_rdata;
    logic              o_bus_clk;
    logic              o_bus_we;
    logic [AW-1:0]     o_bus_addr;
    logic [DW-1:0]     o_bus_data;
    logic [DW-1:0]     i_bus_data;
    logic              i_bus_data_ready;

    typedef struct packed {
        logic [2:0]    ack;
        logic [DW-1:0] rdata;
        logic          err;
    } exp_t;

    exp_t        sb[$];
    int          checks   = 0;
    int          failures = 0;
    int          cyc      = 0;
    int          ack_cyc  = 0;
    int          req_cyc  = 0;
    logic [DW-1:0] last_rd = '0;

    bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYC(TMO)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_req(i_req), .i_we(i_we),
        .i_addr(i_addr), .i_wdata(i_wdata), .o_gnt(o_gnt), .o_ack(o_ack),
        .o_err(o_err), .o_rdata(o_rdata), .o_bus_clk(o_bus_clk), .o_bus_we(o_bus_we),
        .o_bus_addr(o_bus_addr), .o_bus_data(o_bus_data), .i_bus_data(i_bus_data),
        .i_bus_data_ready(i_bus_data_ready)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock, sample 1ns later and retire any completion against the scoreboard
    task automatic tick();
        exp_t e;
        @(posedge i_clk);
        #1;
        cyc++;
        if (o_ack !== 3'b000) begin
            ack_cyc = cyc;
            if (sb.size() == 0) begin
                chk("unexpected_ack", 64'(o_ack), 64'(0));
            end else begin
                e = sb.pop_front();
                chk("ack", 64'(o_ack), 64'(e.ack));
                chk("rdata", 64'(o_rdata), 64'(e.rdata));
                chk("err", 64'(o_err), 64'(e.err));
            end
        end else begin
            chk("err_without_ack", 64'(o_err), 64'(0));
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_gnt"},      64'(o_gnt), 64'(0));
        chk({tag, "_ack"},      64'(o_ack), 64'(0));
        chk({tag, "_err"},      64'(o_err), 64'(0));
        chk({tag, "_bus_clk"},  64'(o_bus_clk), 64'(0));
        chk({tag, "_bus_we"},   64'(o_bus_we), 64'(0));
        chk({tag, "_bus_addr"}, 64'(o_bus_addr), 64'(0));
        chk({tag, "_bus_data"}, 64'(o_bus_data), 64'(0));
        chk({tag, "_rdata"},    64'(o_rdata), 64'(0));
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "bench time limit");
    end

    initial begin
        int exp_k;
        i_rst = 1'b1; i_req = '0; i_we = '0; i_addr = '0; i_wdata = '0;
        i_bus_data = '0; i_bus_data_ready = 1'b0;
        tick(); tick();
        chk_all_zero("reset");
        i_rst = 1'b0;

        // Single read from CPU, ready in the 2nd BUS cycle
        i_req = 3'b001; i_addr[0 +: AW] = 32'h1234; req_cyc = cyc;
        tick();
        chk("rd_gnt", 64'(o_gnt), 64'(3'b001));
        chk("rd_bus_clk", 64'(o_bus_clk), 64'(1));
        chk("rd_bus_addr", 64'(o_bus_addr), 64'(32'h1234));
        chk("rd_bus_we", 64'(o_bus_we), 64'(0));
        tick();
        chk("rd_wait_gnt", 64'(o_gnt), 64'(3'b001));
        chk("rd_wait_ack", 64'(o_ack), 64'(0));
        i_bus_data_ready = 1'b1; i_bus_data = 32'hA5; last_rd = 32'hA5;
        sb.push_back(exp_t'{3'b001, 32'hA5, 1'b0});
        tick();
        chk("rd_done_gnt", 64'(o_gnt), 64'(0));
        chk("rd_done_bus_clk", 64'(o_bus_clk), 64'(0));
        // request cycle counts as cycle 1
        chk("rd_latency", 64'(ack_cyc - req_cyc + 1), 64'(4));
        i_req = '0; i_bus_data_ready = 1'b0; i_bus_data = '0;
        tick(); tick();

        // Write from DMA; bus read data must not reach o_rdata
        i_req = 3'b010; i_we = 3'b010; i_addr[AW +: AW] = 32'h20; i_wdata[DW +: DW] = 32'hDEADBEEF;
        tick();
        chk("wr_gnt", 64'(o_gnt), 64'(3'b010));
        chk("wr_bus_clk", 64'(o_bus_clk), 64'(1));
        chk("wr_bus_we", 64'(o_bus_we), 64'(1));
        chk("wr_bus_addr", 64'(o_bus_addr), 64'(32'h20));
        chk("wr_bus_data", 64'(o_bus_data), 64'(32'hDEADBEEF));
        i_bus_data_ready = 1'b1; i_bus_data = 32'h55;
        sb.push_back(exp_t'{3'b010, last_rd, 1'b0});
        tick();
        chk("wr_hold_bus_data", 64'(o_bus_data), 64'(32'hDEADBEEF));
        // ready stays high after ack while CPU already requests
        i_req = 3'b001; i_we = '0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("recover_no_gnt", 64'(o_gnt), 64'(0));
        end
        i_bus_data_ready = 1'b0;
        tick();
        chk("recover_exit_gnt", 64'(o_gnt), 64'(0));
        tick();
        chk("after_recover_gnt", 64'(o_gnt), 64'(3'b001));
        chk("after_recover_addr", 64'(o_bus_addr), 64'(32'h1234));
        i_bus_data_ready = 1'b1; i_bus_data = 32'h77; last_rd = 32'h77;
        sb.push_back(exp_t'{3'b001, 32'h77, 1'b0});
        tick();
        i_req = '0; i_bus_data_ready = 1'b0;
        tick(); tick();

        // Contention from reset: all requesters held high
        i_rst = 1'b1; i_req = 3'b111;
        tick();
        i_rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            exp_k = k % 3;
            tick();
            chk("cont_gnt", 64'(o_gnt), 64'(3'b001 << exp_k));
            chk("cont_onehot", 64'($onehot(o_gnt)), 64'(1));
            i_bus_data_ready = 1'b1; i_bus_data = DW'(32'h100 + k); last_rd = DW'(32'h100 + k);
            sb.push_back(exp_t'{3'(3'b001 << exp_k), DW'(32'h100 + k), 1'b0});
            tick();
            i_bus_data_ready = 1'b0;
            tick();
        end
        i_req = '0;
        tick();

        // Watchdog: debug requester, bus never ready
        i_req = 3'b100;
        tick();
        chk("tmo_gnt", 64'(o_gnt), 64'(3'b100));
`ifdef BUS_ARBITER_TIMEOUT_EN
        sb.push_back(exp_t'{3'b100, last_rd, 1'b1});
        for (int i = 0; i < int'(TMO) - 1; i++) begin
            tick();
            chk("tmo_early_ack", 64'(o_ack), 64'(0));
        end
        tick();
        chk("tmo_bus_clk", 64'(o_bus_clk), 64'(0));
        i_req = '0;
        tick(); tick();
`else
        for (int i = 0; i < 1000; i++) begin
            tick();
        end
        chk("no_tmo_gnt", 64'(o_gnt), 64'(3'b100));
        chk("no_tmo_bus_clk", 64'(o_bus_clk), 64'(1));
        i_req = '0; i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
        tick();
`endif

        // Reset in the middle of a DMA write
        i_req = 3'b010; i_we = 3'b010;
        tick();
        chk("mid_gnt", 64'(o_gnt), 64'(3'b010));
        tick();
        i_rst = 1'b1;
        #1;
        chk_all_zero("async_rst");
        tick(); tick();
        i_rst = 1'b0; i_req = 3'b110;
        tick();
        chk("post_rst_gnt", 64'(o_gnt), 64'(3'b010));
        i_bus_data_ready = 1'b1; i_bus_data = 32'h99;
        sb.push_back(exp_t'{3'b010, DW'(0), 1'b0});
        tick();
        i_req = '0; i_we = '0; i_bus_data_ready = 1'b0;
        tick(); tick();

        chk("sb_empty", 64'(sb.size()), 64'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
